// File: rtl/priority_encoder_4_to_2_pkg.sv
// Shared types and constants for the registered priority encoder.
// Optional build feature: PRIORITY_ENCODER_ROUND_ROBIN_EN (round-robin selection).
package encoder_pkg;

   // Default number of request lines (power of two, at least 2).
   localparam int N_DEF = 4;

   // Code width for n request lines; derived from n, never set by hand.
   function automatic int code_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Output slot state: IDLE = slot empty, HOLD = code_out holds a granted index.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } enc_state_t;

endpackage

// File: rtl/priority_encoder_4_to_2_if.sv
// Request/grant bus of the priority encoder.
// Handshake: valid_out/code_out are presented by the encoder; a code is
// consumed on a rising clk edge where valid_out=1 and ready_in=1. While
// valid_out=1 and ready_in=0 the encoder keeps valid_out and code_out
// unchanged. ready_in is ignored while valid_out=0.
// dbg_state exposes the output-slot FSM state for checkers.
interface priority_encoder_4_to_2_if #(
   parameter int N = encoder_pkg::N_DEF
);
   localparam int W = encoder_pkg::code_w(N);

   logic [N-1:0]            req_in;
   logic                    ready_in;
   logic                    valid_out;
   logic [W-1:0]            code_out;
   logic [N-1:0]            pending_out;
   logic                    overflow;
   encoder_pkg::enc_state_t dbg_state;

   // Encoder side
   modport slave (
      input  req_in, ready_in,
      output valid_out, code_out, pending_out, overflow, dbg_state
   );

   // Request source / consumer side
   modport master (
      output req_in, ready_in,
      input  valid_out, code_out, pending_out, overflow, dbg_state
   );
endinterface

// File: rtl/priority_encoder_4_to_2_enc_pick.sv
// Combinational find-first over N request bits, starting the search at
// i_start and wrapping modulo N. Returns the first set index, its one-hot
// mask and a found flag.
module enc_pick
   import encoder_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = code_w(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_start,
   output logic         o_found,
   output logic [W-1:0] o_index,
   output logic [N-1:0] o_onehot
);

   logic [W-1:0] w_idx;

   // Scan from the farthest offset back to i_start so the nearest hit wins.
   always_comb begin
      o_found  = 1'b0;
      o_index  = '0;
      o_onehot = '0;
      w_idx    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         // N is a power of two, so W-bit wrap-around is the modulo.
         w_idx = i_start + k[W-1:0];
         if (i_req[w_idx]) begin
            o_found = 1'b1;
            o_index = w_idx;
         end
      end
      if (o_found) begin
         o_onehot[o_index] = 1'b1;
      end
   end

endmodule

// File: rtl/priority_encoder_4_to_2.sv
// Registered N-to-log2(N) priority encoder with per-line request buffering.
// Requests are latched into a pending vector; one pending line at a time is
// moved into the output register and presented over valid/ready.
// Build option PRIORITY_ENCODER_ROUND_ROBIN_EN: round-robin selection starting
// after the last granted line; otherwise fixed priority, lowest index first.
module priority_encoder_4_to_2
   import encoder_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   priority_encoder_4_to_2_if.slave  bus
);

   localparam int W = code_w(N);

   enc_state_t   r_state;
   logic [W-1:0] r_code;
   logic [N-1:0] r_pending;
   logic         r_overflow;

   logic [W-1:0] w_start;
   logic         w_found;
   logic [W-1:0] w_index;
   logic [N-1:0] w_onehot;
   logic         w_slot_free;
   logic         w_load;
   logic [N-1:0] w_load_mask;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
   logic [W-1:0] r_last;

   // Remember the last granted line; resetting to N-1 makes the first search start at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= W'(N - 1);
      end else if (w_load) begin
         r_last <= w_index;
      end
   end

   assign w_start = r_last + 1'b1;
`else
   assign w_start = '0;
`endif

   // Selection looks only at registered pending bits, never at this cycle's req_in.
   enc_pick #(
      .N (N),
      .W (W)
   ) u_pick (
      .i_req    (r_pending),
      .i_start  (w_start),
      .o_found  (w_found),
      .o_index  (w_index),
      .o_onehot (w_onehot)
   );

   assign w_slot_free = (r_state == IDLE) || bus.ready_in;
   assign w_load      = w_slot_free && w_found;
   assign w_load_mask = w_load ? w_onehot : '0;

   // Output-slot FSM, pending buffer and overflow flag; new requests win over load clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_code     <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_pending  <= (r_pending & ~w_load_mask) | bus.req_in;
         r_overflow <= |(bus.req_in & r_pending & ~w_load_mask);
         if (w_slot_free) begin
            if (w_found) begin
               r_state <= HOLD;
               r_code  <= w_index;
            end else begin
               r_state <= IDLE;
               r_code  <= '0;
            end
         end
      end
   end

   assign bus.valid_out   = (r_state == HOLD);
   assign bus.code_out    = r_code;
   assign bus.pending_out = r_pending;
   assign bus.overflow    = r_overflow;
   assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_priority_encoder_4_to_2.sv
// Bench for priority_encoder_4_to_2: directed vector table, an async reset
// sequence, and randomized traffic checked against a reference model.
module tb_priority_encoder_4_to_2;
  import encoder_pkg::*;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int VW = W + N + 2;   // {valid, code, pending, overflow}

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  priority_encoder_4_to_2_if #(.N(N)) bus();

  priority_encoder_4_to_2 #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [VW-1:0] exp_q[$];

  typedef struct {
    bit          rst_before;
    logic [N-1:0] req;
    logic        rdy;
    logic [VW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [VW-1:0] pack(input logic v, input logic [W-1:0] c,
                                         input logic [N-1:0] p, input logic o);
    return {v, c, p, o};
  endfunction

  function automatic vec_t mk(input bit r, input logic [N-1:0] req, input logic rdy,
                              input logic v, input logic [W-1:0] c,
                              input logic [N-1:0] p, input logic o);
    vec_t t;
    t.rst_before = r;
    t.req = req;
    t.rdy = rdy;
    t.exp = pack(v, c, p, o);
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [VW-1:0] exp);
    logic [VW-1:0] act;
    act = {bus.valid_out, bus.code_out, bus.pending_out, bus.overflow};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got valid=%0b code=%0d pending=%b ovf=%0b, expected valid=%0b code=%0d pending=%b ovf=%0b",
               name, act[7], act[6:5], act[4:1], act[0], exp[7], exp[6:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check_state(input string name, input enc_state_t exp);
    n_checks++;
    if (bus.dbg_state !== exp) begin
      n_errors++;
      $display("FAIL %s: got state=%0d, expected state=%0d", name, bus.dbg_state, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_pend[N];
  bit m_valid;
  int m_code;
  int m_last;
  bit m_ovf;

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_code  = 0;
    m_last  = N - 1;
    m_ovf   = 1'b0;
  endfunction

  // Advance the model by one clock with the given inputs; push the expected outputs.
  function automatic void model_step(input logic [N-1:0] req, input logic rdy);
    bit free;
    int pick;
    int start;
    logic [N-1:0] pv;
    free  = !m_valid || rdy;
    pick  = -1;
    start = RR ? (m_last + 1) % N : 0;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && m_pend[(start + k) % N]) pick = (start + k) % N;
      end
    end
    m_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && m_pend[i] && i != pick) m_ovf = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      m_pend[i] = (m_pend[i] && i != pick) || req[i];
    end
    if (free) begin
      if (pick >= 0) begin
        m_valid = 1'b1;
        m_code  = pick;
        m_last  = pick;
      end else begin
        m_valid = 1'b0;
        m_code  = 0;
      end
    end
    for (int i = 0; i < N; i++) pv[i] = m_pend[i];
    exp_q.push_back(pack(m_valid, W'(m_code), pv, m_ovf));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_step(input logic [N-1:0] req, input logic rdy);
    bus.req_in   = req;
    bus.ready_in = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_in   = '0;
    bus.ready_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", pack(1'b0, '0, '0, 1'b0));
    check_state("reset_state", IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // ---------------- test ----------------
  initial begin
    logic [N-1:0] r_req;
    logic         r_rdy;
    logic [VW-1:0] e;

    bus.req_in   = '0;
    bus.ready_in = 1'b0;
    rst_n        = 1'b1;
    #2;

    // Single request
    vecs.push_back(mk(1, 4'b0100, 1, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 2, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0));
    // Multiple lines, back-to-back
    vecs.push_back(mk(1, 4'b1011, 1, 0, 0, 4'b1011, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b1010, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 1, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 3, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0));
    // Backpressure: ready_in low while IDLE is ignored, then hold
    vecs.push_back(mk(1, 4'b0110, 0, 0, 0, 4'b0110, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 2, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0));
    // Overflow while the slot is held
    vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 0, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 2, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0));
    // Set wins over load clear on line 0; held line re-request is not overflow
    vecs.push_back(mk(1, 4'b0001, 1, 0, 0, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 1, 0, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0));
    // Grant order: round-robin 0,1,0 ; fixed 0,0,1
    vecs.push_back(mk(1, 4'b0011, 1, 0, 0, 4'b0011, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 1, 0, 4'b0011, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, RR ? 2'd1 : 2'd0, RR ? 4'b0001 : 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, RR ? 2'd0 : 2'd1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      drive_step(vecs[i].req, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Async reset mid-transfer: valid held with pending 1100
    do_reset();
    drive_step(4'b0001, 1'b0);
    drive_step(4'b1100, 1'b0);
    check("pre_reset_hold", pack(1'b1, 2'd0, 4'b1100, 1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", pack(1'b0, 2'd0, 4'b0000, 1'b0));
    check_state("async_reset_state", IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_step(4'b0000, 1'b1);
      check($sformatf("post_reset_quiet%0d", i), pack(1'b0, 2'd0, 4'b0000, 1'b0));
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r_req = ($urandom_range(0, 2) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      r_rdy = ($urandom_range(0, 3) != 0);
      model_step(r_req, r_rdy);
      drive_step(r_req, r_rdy);
      e = exp_q.pop_front();
      check($sformatf("rand%0d", i), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
